riscv_cpu: RTL and testbench
============================

Name: riscv_cpu

Overview:
- Single-cycle RV32I-subset processor core: one instruction fetched, decoded, executed and retired per rising clock edge.
- Contains the PC, a 32x32 register file, a word-addressed instruction memory and a word-addressed data memory.
- Top-level block of the core; its only external inputs are clock and reset.
- Internal state is reached hierarchically by benches and must use these instance/signal names:
  - pc
  - instruction_memory.mem[]
  - data_memory.mem[]
  - reg_file.registers[]

Parameters:
- IMEM_WORDS, 64: instruction memory depth in 32-bit words.
- DMEM_WORDS, 32: data memory depth in 32-bit words (byte addresses 0..124).
- RESET_PC, 32'h0000_0000: PC value while reset is asserted.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted = 0). The port is named reset as in the codebase; its polarity is active-low.

Behaviour:
- Reset asserted: pc forced to RESET_PC immediately, with no clock required.
- Reset does not clear the register file, instruction memory or data memory. Contents written while reset is held are preserved.
- No register-file or memory writes occur while reset is asserted.
- Fetch: instruction = instruction_memory.mem[pc[31:2]] (combinational). Out-of-range index reads 0.
- Memory initial contents are all zero. Register file initial contents are all zero.
- Each posedge with reset deasserted:
  - pc <= next_pc.
  - rd written if the instruction writes a register and rd != 0.
  - data memory written for sw.
- Register file: 2 combinational read ports. x0 always reads 0; writes to x0 are discarded, so registers[0] stays 0.
- Immediates are sign-extended:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Supported instructions:
  - R-type (0110011): add, sub (funct7[5]=1), and, or, xor, slt (signed), sltu, sll, srl, sra.
  - I-type ALU (0010011): addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - lw (0000011, funct3 010): rd <= dmem[(rs1+immI)[..:2]].
  - sw (0100011, funct3 010): dmem[(rs1+immS)[..:2]] <= rs2.
  - beq/bne (1100011, funct3 000/001): if taken, next_pc = pc + immB; else pc + 4.
  - jal (1101111): rd <= pc + 4; next_pc = pc + immJ.
  - jalr (1100111): rd <= pc + 4; next_pc = (rs1 + immI) & ~1, computed from the rs1 value read before the write.
- Data memory: low 2 address bits ignored (word access only). Out-of-range loads return 0; out-of-range stores are dropped. Load data is combinational, so a load result is written the same cycle and is usable by the next instruction with no stall.
- Arithmetic is 32-bit wrap-around. Shift amounts use the low 5 bits.
- Any other opcode or funct3 executes as a NOP: pc + 4, no writes.
- Reset asserted mid-stream takes effect asynchronously; the in-flight instruction does not retire.

Optional Feature:
- CPU_TRACE_EN defined: on every retiring posedge the core prints (simulation only) pc, instruction, rd and the write-back value, plus the address and data for stores.
- Undefined: no trace logic or output. Functional behaviour is identical in both cases.

Test Plan:
1. Reset sequence: hold reset=0 with dmem[0]=DEADBEEF, imem[0]=lw x1,0(x0), imem[1]=sw x1,4(x0); release reset -> after 1 clock x1=DEADBEEF; after 2 clocks dmem[1]=DEADBEEF.
2. ALU ops with x1=15, x2=5: add x4 -> 0x14; sub x5 -> 0xA; and x6 -> 5; or x7 -> 0xF; slt x8,x2,x1 -> 1. Immediates: addi x9,x0,1 -> 1; addi x10,x9,-1 -> 0; addi 2047 -> 0x7FF; addi -2048 -> 0xFFFFF800; addi x0,x0,-1 -> x0 stays 0.
3. Branches:
   - beq x11,x12,+8 at pc 0x1C with both =7 -> pc=0x24 and the skipped instruction does not write.
   - bne with equal operands at 0x28 -> pc=0x2C, and the following addi x17=3 executes.
4. Jumps:
   - jal x18,+8 at 0x30 -> x18=0x34, pc=0x38.
   - jalr x22,4(x21) at 0x3C with x21=0x40 -> x22=0x40, pc=0x44.
5. Memory boundary: sw to 124(x0) -> dmem[31] updated. Load-use: lw x28,40(x0) with dmem[10]=0xFF then addi x29,x28,1 -> x28=0xFF, x29=0x100.
6. Asynchronous reset: drive reset low between clock edges -> pc=0 immediately, and register-file contents are retained.

Source files
------------

// File: rtl/riscv_cpu.sv
// riscv_cpu: single-cycle RV32I-subset core with internal instruction/data memories and register file.
// Defining CPU_TRACE_EN adds a simulation-only retirement trace; behaviour is otherwise identical.

module riscv_word_mem #(
    parameter int WORDS = 32
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]   mem [0:WORDS-1];
    logic [AW-1:0] idx_s;
    logic          in_range_s;
    logic          unused_addr_s;

    // Byte address in, word index out; the two low bits never select anything.
    assign idx_s         = addr[AW+1:2];
    assign in_range_s    = (addr[31:2] < 30'(WORDS));
    assign unused_addr_s = ^addr[1:0];

    // Combinational read port; out-of-range words read as zero.
    always_comb begin
        if (in_range_s) begin
            rdata = mem[idx_s];
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // Word write port; out-of-range stores are dropped.
    always_ff @(posedge clk) begin
        if (we && in_range_s) begin
            mem[idx_s] <= wdata;
        end
    end
endmodule

module riscv_reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    logic [31:0] registers [0:31];

    // Two asynchronous read ports with x0 hardwired to zero.
    always_comb begin
        rdata_a = (raddr_a == 5'd0) ? 32'h0000_0000 : registers[raddr_a];
        rdata_b = (raddr_b == 5'd0) ? 32'h0000_0000 : registers[raddr_b];
    end

    // Write port; x0 writes are discarded so registers[0] never changes.
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            registers[waddr] <= wdata;
        end
    end
endmodule

module riscv_cpu #(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0] pc;
    logic [31:0] inst_s, rs1_val_s, rs2_val_s, load_data_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s;
    logic [31:0] pc_plus4_s, next_pc_s, wb_data_s, mem_addr_s;
    logic [6:0]  opcode_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  funct3_s;
    logic        rd_we_s, mem_we_s, rf_we_s, dmem_we_s;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic        [4:0]  sh;
        logic signed [31:0] sra_v;
        sh    = b[4:0];
        sra_v = $signed(a) >>> sh;
        case (f3)
            3'b000:  return alt ? (a - b) : (a + b);
            3'b001:  return a << sh;
            3'b010:  return {31'd0, ($signed(a) < $signed(b))};
            3'b011:  return {31'd0, (a < b)};
            3'b100:  return a ^ b;
            3'b101:  return alt ? sra_v : (a >> sh);
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign opcode_s   = inst_s[6:0];
    assign rd_s       = inst_s[11:7];
    assign funct3_s   = inst_s[14:12];
    assign rs1_s      = inst_s[19:15];
    assign rs2_s      = inst_s[24:20];
    assign imm_i_s    = {{20{inst_s[31]}}, inst_s[31:20]};
    assign imm_s_s    = {{20{inst_s[31]}}, inst_s[31:25], inst_s[11:7]};
    assign imm_b_s    = {{19{inst_s[31]}}, inst_s[31], inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0};
    assign imm_j_s    = {{11{inst_s[31]}}, inst_s[31], inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0};
    assign pc_plus4_s = pc + 32'd4;
    assign mem_addr_s = rs1_val_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
    // A held reset suppresses every architectural write, including the in-flight instruction.
    assign rf_we_s    = rd_we_s & reset;
    assign dmem_we_s  = mem_we_s & reset;

    riscv_word_mem #(.WORDS(IMEM_WORDS)) instruction_memory (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc),
        .wdata (32'h0000_0000),
        .rdata (inst_s)
    );

    riscv_reg_file reg_file (
        .clk     (clk),
        .we      (rf_we_s),
        .waddr   (rd_s),
        .wdata   (wb_data_s),
        .raddr_a (rs1_s),
        .raddr_b (rs2_s),
        .rdata_a (rs1_val_s),
        .rdata_b (rs2_val_s)
    );

    riscv_word_mem #(.WORDS(DMEM_WORDS)) data_memory (
        .clk   (clk),
        .we    (dmem_we_s),
        .addr  (mem_addr_s),
        .wdata (rs2_val_s),
        .rdata (load_data_s)
    );

    // Decode/execute: write-back data, write enables and the next PC.
    always_comb begin
        rd_we_s   = 1'b0;
        mem_we_s  = 1'b0;
        wb_data_s = 32'h0000_0000;
        next_pc_s = pc_plus4_s;
        case (opcode_s)
            OP_R: begin
                rd_we_s   = 1'b1;
                wb_data_s = alu(funct3_s, inst_s[30], rs1_val_s, rs2_val_s);
            end
            OP_I: begin
                rd_we_s   = 1'b1;
                wb_data_s = alu(funct3_s, (funct3_s == 3'b101) ? inst_s[30] : 1'b0, rs1_val_s, imm_i_s);
            end
            OP_LOAD: begin
                if (funct3_s == 3'b010) begin
                    rd_we_s   = 1'b1;
                    wb_data_s = load_data_s;
                end else begin
                    rd_we_s   = 1'b0;
                end
            end
            OP_STORE: begin
                if (funct3_s == 3'b010) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            OP_BRANCH: begin
                case (funct3_s)
                    3'b000: begin
                        if (rs1_val_s == rs2_val_s) begin
                            next_pc_s = pc + imm_b_s;
                        end else begin
                            next_pc_s = pc_plus4_s;
                        end
                    end
                    3'b001: begin
                        if (rs1_val_s != rs2_val_s) begin
                            next_pc_s = pc + imm_b_s;
                        end else begin
                            next_pc_s = pc_plus4_s;
                        end
                    end
                    default: next_pc_s = pc_plus4_s;
                endcase
            end
            OP_JAL: begin
                rd_we_s   = 1'b1;
                wb_data_s = pc_plus4_s;
                next_pc_s = pc + imm_j_s;
            end
            OP_JALR: begin
                if (funct3_s == 3'b000) begin
                    rd_we_s   = 1'b1;
                    wb_data_s = pc_plus4_s;
                    next_pc_s = (rs1_val_s + imm_i_s) & ~32'h0000_0001;
                end else begin
                    rd_we_s   = 1'b0;
                end
            end
            default: rd_we_s = 1'b0;
        endcase
    end

    // Program counter with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc_s;
        end
    end

`ifdef CPU_TRACE_EN
    // Simulation-only retirement trace.
    always @(posedge clk) begin
        if (reset) begin
            if (dmem_we_s) begin
                $display("[trace] pc=%h inst=%h store addr=%h data=%h", pc, inst_s, mem_addr_s, rs2_val_s);
            end else begin
                $display("[trace] pc=%h inst=%h rd=%0d wb=%h", pc, inst_s, rf_we_s ? rd_s : 5'd0, wb_data_s);
            end
        end
    end
`endif
endmodule

// File: tb/tb_riscv_cpu.sv
// Self-checking bench for riscv_cpu: programs are loaded hierarchically under reset,
// expected architectural state is queued and compared once the program has run.

module tb_riscv_cpu;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_PC  = 2;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] got;
    int          n_checks = 0;
    int          n_fail = 0;

    riscv_cpu dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP_R};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], OP_STORE};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], OP_BRANCH};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), OP_JAL};
    endfunction

    function automatic logic [31:0] observe(int kind, int idx);
        case (kind)
            K_REG:   return dut.reg_file.registers[idx];
            K_MEM:   return dut.data_memory.mem[idx];
            default: return dut.pc;
        endcase
    endfunction

    task automatic expect_val(int kind, int idx, logic [31:0] val, string name);
        exp_t x;
        x.kind = kind; x.idx = idx; x.val = val; x.name = name;
        sb.push_back(x);
    endtask

    // Assert reset and wipe all state so each scenario starts from zero.
    task automatic begin_prog();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) dut.instruction_memory.mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) dut.data_memory.mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) dut.reg_file.registers[i] = 32'h0;
    endtask

    task automatic run_cycles(int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        begin_prog();
        dut.data_memory.mem[0] = 32'hDEAD_BEEF;
        dut.instruction_memory.mem[0] = enc_i(0, 0, 2, 1, OP_LOAD);
        dut.instruction_memory.mem[1] = enc_s(4, 1, 0);
        repeat (3) @(negedge clk);
        expect_val(K_PC, 0, 32'h0, "pc_in_reset");
        expect_val(K_REG, 1, 32'h0, "no_reg_write_in_reset");
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
        expect_val(K_REG, 1, 32'hDEAD_BEEF, "lw_after_reset");
        expect_val(K_MEM, 1, 32'h0, "sw_not_yet");
        run_cycles(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
        expect_val(K_MEM, 1, 32'hDEAD_BEEF, "sw_after_reset");
        expect_val(K_PC, 0, 32'h8, "pc_after_two");
        run_cycles(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
    endtask

    task automatic test_alu();
        logic [31:0] prog [25];
        begin_prog();
        dut.reg_file.registers[1]  = 32'd15;
        dut.reg_file.registers[2]  = 32'd5;
        dut.reg_file.registers[3]  = 32'd33;
        dut.reg_file.registers[10] = 32'h55;
        prog = '{enc_r(0, 2, 1, 0, 4), enc_r(32, 2, 1, 0, 5), enc_r(0, 2, 1, 7, 6), enc_r(0, 2, 1, 6, 7),
                 enc_r(0, 1, 2, 2, 8), enc_i(1, 0, 0, 9, OP_I), enc_i(-1, 9, 0, 10, OP_I),
                 enc_i(2047, 0, 0, 11, OP_I), enc_i(-2048, 0, 0, 12, OP_I), enc_i(-1, 0, 0, 0, OP_I),
                 enc_r(0, 2, 1, 4, 13), enc_r(0, 1, 12, 3, 14), enc_r(0, 1, 12, 2, 15),
                 enc_r(0, 2, 1, 1, 16), enc_r(32, 2, 12, 5, 17), enc_r(0, 2, 12, 5, 18),
                 enc_i(32'h404, 12, 5, 19, OP_I), enc_i(31, 1, 1, 20, OP_I), enc_i(16, 1, 3, 21, OP_I),
                 enc_i(-1, 1, 4, 22, OP_I), enc_i(6, 1, 7, 23, OP_I), enc_i(8, 2, 6, 24, OP_I),
                 enc_i(28, 12, 5, 25, OP_I), enc_i(0, 12, 2, 26, OP_I), enc_r(0, 3, 1, 1, 27)};
        for (int i = 0; i < 25; i++) dut.instruction_memory.mem[i] = prog[i];
        expect_val(K_REG, 4, 32'h14, "add");          expect_val(K_REG, 5, 32'hA, "sub");
        expect_val(K_REG, 6, 32'h5, "and");           expect_val(K_REG, 7, 32'hF, "or");
        expect_val(K_REG, 8, 32'h1, "slt");           expect_val(K_REG, 9, 32'h1, "addi_1");
        expect_val(K_REG, 10, 32'h0, "addi_m1");      expect_val(K_REG, 11, 32'h7FF, "addi_2047");
        expect_val(K_REG, 12, 32'hFFFF_F800, "addi_m2048");
        expect_val(K_REG, 0, 32'h0, "x0_stays_zero"); expect_val(K_REG, 13, 32'hA, "xor");
        expect_val(K_REG, 14, 32'h0, "sltu");         expect_val(K_REG, 15, 32'h1, "slt_neg");
        expect_val(K_REG, 16, 32'h1E0, "sll");        expect_val(K_REG, 17, 32'hFFFF_FFC0, "sra");
        expect_val(K_REG, 18, 32'h07FF_FFC0, "srl");  expect_val(K_REG, 19, 32'hFFFF_FF80, "srai");
        expect_val(K_REG, 20, 32'h8000_0000, "slli"); expect_val(K_REG, 21, 32'h1, "sltiu");
        expect_val(K_REG, 22, 32'hFFFF_FFF0, "xori");  expect_val(K_REG, 23, 32'h6, "andi");
        expect_val(K_REG, 24, 32'hD, "ori");          expect_val(K_REG, 25, 32'hF, "srli");
        expect_val(K_REG, 26, 32'h1, "slti");         expect_val(K_REG, 27, 32'h1E, "sll_shamt5");
        expect_val(K_PC, 0, 32'h64, "alu_pc");
        run_cycles(25);
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
    endtask

    task automatic test_branch();
        begin_prog();
        dut.reg_file.registers[11] = 32'd7;
        dut.reg_file.registers[12] = 32'd7;
        dut.reg_file.registers[15] = 32'd6;
        dut.reg_file.registers[13] = 32'hA5A5;
        for (int i = 0; i < 7; i++) dut.instruction_memory.mem[i] = enc_i(0, 0, 0, 0, OP_I);
        dut.instruction_memory.mem[7]  = enc_b(8, 12, 11, 0);
        dut.instruction_memory.mem[8]  = enc_i(99, 0, 0, 13, OP_I);
        dut.instruction_memory.mem[9]  = enc_i(1, 0, 0, 14, OP_I);
        dut.instruction_memory.mem[10] = enc_b(8, 12, 11, 1);
        dut.instruction_memory.mem[11] = enc_i(3, 0, 0, 17, OP_I);
        dut.instruction_memory.mem[12] = enc_b(12, 15, 11, 1);
        dut.instruction_memory.mem[13] = enc_i(55, 0, 0, 13, OP_I);
        dut.instruction_memory.mem[15] = enc_b(8, 15, 11, 0);
        expect_val(K_REG, 13, 32'hA5A5, "skipped_no_write");
        expect_val(K_REG, 14, 32'h1, "branch_target_exec");
        expect_val(K_REG, 17, 32'h3, "bne_fallthrough_exec");
        expect_val(K_PC, 0, 32'h40, "branch_final_pc");
        run_cycles(8);
        n_checks++;
        if (dut.pc !== 32'h24) begin n_fail++; $display("FAIL beq_taken_pc: observed %h expected %h", dut.pc, 32'h24); end
        run_cycles(2);
        n_checks++;
        if (dut.pc !== 32'h2C) begin n_fail++; $display("FAIL bne_not_taken_pc: observed %h expected %h", dut.pc, 32'h2C); end
        run_cycles(2);
        n_checks++;
        if (dut.pc !== 32'h3C) begin n_fail++; $display("FAIL bne_taken_pc: observed %h expected %h", dut.pc, 32'h3C); end
        run_cycles(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
    endtask

    task automatic test_jump();
        begin_prog();
        for (int i = 0; i < 12; i++) dut.instruction_memory.mem[i] = enc_i(0, 0, 0, 0, OP_I);
        dut.instruction_memory.mem[12] = enc_j(8, 18);
        dut.instruction_memory.mem[13] = enc_i(7, 0, 0, 19, OP_I);
        dut.instruction_memory.mem[14] = enc_i(32'h40, 0, 0, 21, OP_I);
        dut.instruction_memory.mem[15] = enc_i(4, 21, 0, 22, OP_JALR);
        dut.instruction_memory.mem[16] = enc_i(1, 23, 0, 23, OP_I);
        dut.instruction_memory.mem[17] = enc_i(1, 21, 0, 21, OP_JALR);
        dut.instruction_memory.mem[18] = enc_j(-72, 24);
        expect_val(K_REG, 18, 32'h34, "jal_link");
        expect_val(K_REG, 19, 32'h0, "jal_skipped");
        expect_val(K_REG, 22, 32'h40, "jalr_link");
        expect_val(K_REG, 21, 32'h48, "jalr_old_rs1_bit0");
        expect_val(K_REG, 23, 32'h1, "jalr_target_exec");
        expect_val(K_REG, 24, 32'h4C, "jal_back_link");
        expect_val(K_PC, 0, 32'h0, "jal_back_pc");
        run_cycles(13);
        n_checks++;
        if (dut.pc !== 32'h38) begin n_fail++; $display("FAIL jal_pc: observed %h expected %h", dut.pc, 32'h38); end
        run_cycles(2);
        n_checks++;
        if (dut.pc !== 32'h44) begin n_fail++; $display("FAIL jalr_pc: observed %h expected %h", dut.pc, 32'h44); end
        run_cycles(4);
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
    endtask

    task automatic test_memory();
        begin_prog();
        dut.reg_file.registers[5]  = 32'h1234_5678;
        dut.reg_file.registers[6]  = 32'h20;
        dut.reg_file.registers[30] = 32'h77;
        dut.data_memory.mem[0]     = 32'h11;
        dut.data_memory.mem[10]    = 32'hFF;
        dut.instruction_memory.mem[0] = enc_s(124, 5, 0);
        dut.instruction_memory.mem[1] = enc_s(128, 5, 0);
        dut.instruction_memory.mem[2] = enc_i(40, 0, 2, 28, OP_LOAD);
        dut.instruction_memory.mem[3] = enc_i(1, 28, 0, 29, OP_I);
        dut.instruction_memory.mem[4] = enc_i(128, 0, 2, 30, OP_LOAD);
        dut.instruction_memory.mem[5] = enc_s(-4, 5, 6);
        dut.instruction_memory.mem[6] = enc_i(124, 0, 2, 31, OP_LOAD);
        dut.instruction_memory.mem[7] = enc_i(43, 0, 2, 27, OP_LOAD);
        expect_val(K_MEM, 31, 32'h1234_5678, "sw_top_word");
        expect_val(K_MEM, 0, 32'h11, "sw_oob_dropped");
        expect_val(K_REG, 28, 32'hFF, "lw_load_use");
        expect_val(K_REG, 29, 32'h100, "addi_after_lw");
        expect_val(K_REG, 30, 32'h0, "lw_oob_zero");
        expect_val(K_MEM, 7, 32'h1234_5678, "sw_neg_offset");
        expect_val(K_REG, 31, 32'h1234_5678, "lw_top_word");
        expect_val(K_REG, 27, 32'hFF, "lw_low_bits_ignored");
        expect_val(K_MEM, 10, 32'hFF, "dmem10_untouched");
        run_cycles(8);
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
    endtask

    task automatic test_async_reset();
        begin_prog();
        for (int i = 0; i < 8; i++) dut.instruction_memory.mem[i] = enc_i(1, 1, 0, 1, OP_I);
        run_cycles(3);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (dut.pc !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: observed %h expected %h", dut.pc, 32'h0); end
        expect_val(K_REG, 1, 32'h3, "regs_kept_in_reset");
        expect_val(K_PC, 0, 32'h0, "pc_held_in_reset");
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
        expect_val(K_REG, 1, 32'h4, "resume_after_reset");
        expect_val(K_PC, 0, 32'h4, "resume_pc");
        run_cycles(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = observe(e.kind, e.idx); n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, got, e.val); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_memory();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
